jtag_ir_dr_ctrl: RTL and testbench
==================================

# jtag_ir_dr_ctrl

This block is the instruction and data-register controller that sits behind the JTAG TAP state machine. It owns the instruction register (IR) and decodes the latched instruction. It implements the BYPASS and IDCODE data registers and routes user data-register scans to external debug DRs. It also retimes TDO on the falling edge of TCK. It is sequenced entirely by the TAP's per-state control flags.

## Interface

Parameters:
- IR_W, 5: instruction register width, minimum 2.
- IDCODE_VAL, 32'h1000_0001: IDCODE DR capture value; bit 0 must be 1.
- OP_IDCODE, 5'h01: IDCODE opcode.
- OP_USER0, 5'h10: opcode routed to external DR 0.
- OP_USER1, 5'h11: opcode routed to external DR 1.
- BYPASS is the all-ones opcode. Every undecoded opcode also selects BYPASS.

Ports:
- tck, input, 1: JTAG clock.
- trst, input, 1: reset, asynchronous, active-low.
- tdi, input, 1: serial data in.
- tlr_n, input, 1: low while the TAP is in Test-Logic-Reset.
- select, input, 1: 1 selects the IR path, 0 selects the DR path.
- capture_ir, shift_ir, update_ir: inputs, 1 bit each, TAP state flags.
- capture_dr, shift_dr, update_dr: inputs, 1 bit each, TAP state flags.
- tdo_en, input, 1: TAP output-enable flag.
- tdo, output, 1: serial data out, registered on falling tck.
- tdo_oe, output, 1: equals tdo_en.
- ir_out, output, IR_W: the latched instruction.
- user_sel, output, 2: one-hot select, bit0 = USER0 active, bit1 = USER1 active.
- user_capture, user_shift, user_update: outputs, 1 bit each. Each is the matching DR flag gated by (|user_sel).
- user_tdi, output, 1: equals tdi.
- user_tdo, input, 2: LSB of each external DR.

## Operation

State flags:
- Flags are levels and are valid for the whole TCK period of the corresponding TAP state.
- Shift-register actions happen on rising tck.
- IR latch and TDO actions happen on falling tck.

IR shift register (ir_sr, IR_W bits), updated on rising tck:
- capture_ir: ir_sr <= {0…0, 2'b01}, the IEEE capture pattern in the LSBs.
- shift_ir: ir_sr <= {tdi, ir_sr[IR_W-1:1]}, shifted LSB-first.
- Otherwise ir_sr holds its value.

Latched instruction (ir_out), updated on falling tck:
- If tlr_n = 0: ir_out <= OP_IDCODE.
- Else if update_ir = 1: ir_out <= ir_sr.
- tlr_n = 0 has priority over update_ir.

Decode (combinational from ir_out):
- OP_IDCODE selects the IDCODE DR.
- OP_USER0 / OP_USER1 set user_sel = 01 / 10.
- All other opcodes select BYPASS, with user_sel = 00.

BYPASS register (1 bit), rising tck:
- capture_dr: cleared to 0.
- shift_dr: loaded with tdi.

IDCODE register (32 bits), rising tck:
- capture_dr: loaded with IDCODE_VAL.
- shift_dr: {tdi, id[31:1]}.

Internal DR behaviour:
- Each internal DR updates only while its instruction is active.
- Each internal DR holds otherwise.

TDO mux, falling tck:
- select = 1: tdo <= ir_sr[0].
- select = 0: tdo <= LSB of the DR chosen by ir_out (bypass bit, id[0], user_tdo[0], or user_tdo[1]).
- tdo is updated every falling edge. Only tdo_oe gates whether it is visible.

## Timing

Reset (trst = 0):
- ir_sr = 'b01.
- ir_out = OP_IDCODE.
- bypass = 0.
- id = IDCODE_VAL.
- tdo = 0.
- Derived outputs after reset: user_sel = 00, and all user_* strobes are 0.

Reset release:
- trst deassertion is asynchronous.
- The first action is on the next rising tck.

Latencies:
- The bit shifted into any register on rising edge N appears on tdo at falling edge N+1 (N+1 counting tck rising edges).
- BYPASS: tdi reaches tdo one full tck later.
- ir_out changes at the falling edge inside Update-IR.
- Decode outputs and user_* strobes follow combinationally from ir_out.

Boundary conditions:
- tlr_n low mid-scan forces IDCODE at the next falling edge. The partial ir_sr contents are discarded by the next capture.
- A capture flag and a shift flag active together is illegal TAP input. If it occurs, capture wins.
- An instruction change takes effect only at Update-IR. A DR scan in progress keeps its register.
- tdo_oe is combinational and carries no latency.

## Test plan

- trst pulse, then an IDCODE_VAL = 32'h1000_0001 DR scan of 32 bits with tdi = 0 → tdo emits 1, 0×27, 1, 0, 0, 0 (LSB first), and ir_out = 5'h01.
- IR scan with tdi = 1×5 → tdo emits the capture pattern 1, 0, 0, 0, 0, and ir_out = 5'h1F at Update-IR.
- BYPASS loaded, DR scan with tdi = 1, 0, 1, 1 → tdo emits 0, 1, 0, 1.
- IR loaded with 5'h10 → user_sel = 01, and user_capture/user_shift/user_update track the DR flags. With user_tdo[0] = 1, tdo = 1 during Shift-DR.
- IR loaded with 5'h07 (undecoded) → behaves as BYPASS, user_sel = 00.
- USER1 active, tlr_n pulsed low mid-Shift-DR → ir_out = 5'h01 at the next falling edge, and user_sel = 00.

Source files
------------

// File: rtl/jtag_ir_dr_ctrl.sv
// JTAG instruction/data-register controller sitting behind the TAP FSM.
// Owns the IR, decodes the latched instruction, implements BYPASS and
// IDCODE, routes USER0/USER1 scans to external DRs and retimes TDO on
// falling TCK.
module jtag_ir_dr_ctrl #(
    parameter int unsigned     IR_W       = 5,
    parameter logic [31:0]     IDCODE_VAL = 32'h1000_0001,
    parameter logic [IR_W-1:0] OP_IDCODE  = IR_W'(5'h01),
    parameter logic [IR_W-1:0] OP_USER0   = IR_W'(5'h10),
    parameter logic [IR_W-1:0] OP_USER1   = IR_W'(5'h11)
) (
    input  logic            tck,
    input  logic            trst,
    input  logic            tdi,
    input  logic            tlr_n,
    input  logic            select,
    input  logic            capture_ir,
    input  logic            shift_ir,
    input  logic            update_ir,
    input  logic            capture_dr,
    input  logic            shift_dr,
    input  logic            update_dr,
    input  logic            tdo_en,
    output logic            tdo,
    output logic            tdo_oe,
    output logic [IR_W-1:0] ir_out,
    output logic [1:0]      user_sel,
    output logic            user_capture,
    output logic            user_shift,
    output logic            user_update,
    output logic            user_tdi,
    input  logic [1:0]      user_tdo
);

    localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(2'b01);

    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_USER0,
        DR_USER1
    } dr_sel_e;

    logic [IR_W-1:0] ir_sr_q,  ir_sr_d;
    logic [IR_W-1:0] ir_out_q, ir_out_d;
    logic            bypass_q, bypass_d;
    logic [31:0]     id_q,     id_d;
    logic            tdo_q,    tdo_d;
    dr_sel_e         dr_sel;

    // Instruction decode; anything not explicitly decoded falls back to BYPASS
    always_comb begin
        dr_sel = DR_BYPASS;
        if (ir_out_q == OP_IDCODE) begin
            dr_sel = DR_IDCODE;
        end else if (ir_out_q == OP_USER0) begin
            dr_sel = DR_USER0;
        end else if (ir_out_q == OP_USER1) begin
            dr_sel = DR_USER1;
        end
    end

    // IR shift register next state; capture wins over a simultaneous shift
    always_comb begin
        ir_sr_d = ir_sr_q;
        if (capture_ir) begin
            ir_sr_d = IR_CAPTURE;
        end else if (shift_ir) begin
            ir_sr_d = {tdi, ir_sr_q[IR_W-1:1]};
        end
    end

    // Internal DR next state; each register moves only while selected
    always_comb begin
        bypass_d = bypass_q;
        id_d     = id_q;
        if (dr_sel == DR_BYPASS) begin
            if (capture_dr) begin
                bypass_d = 1'b0;
            end else if (shift_dr) begin
                bypass_d = tdi;
            end
        end
        if (dr_sel == DR_IDCODE) begin
            if (capture_dr) begin
                id_d = IDCODE_VAL;
            end else if (shift_dr) begin
                id_d = {tdi, id_q[31:1]};
            end
        end
    end

    // Latched instruction next state; Test-Logic-Reset overrides Update-IR
    always_comb begin
        ir_out_d = ir_out_q;
        if (!tlr_n) begin
            ir_out_d = OP_IDCODE;
        end else if (update_ir) begin
            ir_out_d = ir_sr_q;
        end
    end

    // TDO source mux: IR LSB on the IR path, else LSB of the decoded DR
    always_comb begin
        tdo_d = 1'b0;
        if (select) begin
            tdo_d = ir_sr_q[0];
        end else begin
            case (dr_sel)
                DR_IDCODE: tdo_d = id_q[0];
                DR_USER0:  tdo_d = user_tdo[0];
                DR_USER1:  tdo_d = user_tdo[1];
                default:   tdo_d = bypass_q;
            endcase
        end
    end

    // Shift-register state advances on rising TCK
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            ir_sr_q  <= IR_CAPTURE;
            bypass_q <= 1'b0;
            id_q     <= IDCODE_VAL;
        end else begin
            ir_sr_q  <= ir_sr_d;
            bypass_q <= bypass_d;
            id_q     <= id_d;
        end
    end

    // Instruction latch and TDO retiming on falling TCK
    always_ff @(negedge tck or negedge trst) begin
        if (!trst) begin
            ir_out_q <= OP_IDCODE;
            tdo_q    <= 1'b0;
        end else begin
            ir_out_q <= ir_out_d;
            tdo_q    <= tdo_d;
        end
    end

    assign ir_out       = ir_out_q;
    assign tdo          = tdo_q;
    assign tdo_oe       = tdo_en;
    assign user_sel     = {dr_sel == DR_USER1, dr_sel == DR_USER0};
    assign user_capture = capture_dr & (|user_sel);
    assign user_shift   = shift_dr   & (|user_sel);
    assign user_update  = update_dr  & (|user_sel);
    assign user_tdi     = tdi;

endmodule

// File: tb/tb_jtag_ir_dr_ctrl.sv
// Scoreboard bench for jtag_ir_dr_ctrl: TAP flag sequences are driven per
// TCK period, expected TDO bits queued as shifts are driven and popped on
// each falling edge where the output is enabled.
module tb_jtag_ir_dr_ctrl;

    localparam int unsigned IR_W = 5;
    localparam logic [31:0] IDV  = 32'h1000_0001;

    logic            tck = 1'b0;
    logic            trst = 1'b1;
    logic            tdi = 1'b0;
    logic            tlr_n = 1'b1;
    logic            select = 1'b0;
    logic            capture_ir = 1'b0, shift_ir = 1'b0, update_ir = 1'b0;
    logic            capture_dr = 1'b0, shift_dr = 1'b0, update_dr = 1'b0;
    logic            tdo_en = 1'b0;
    logic            tdo, tdo_oe;
    logic [IR_W-1:0] ir_out;
    logic [1:0]      user_sel;
    logic            user_capture, user_shift, user_update, user_tdi;
    logic [1:0]      user_tdo = 2'b00;

    logic            tdo_exp_q[$];
    int              n_tests = 0;
    int              n_fail = 0;
    logic            exp_user_act = 1'b0;
    logic [IR_W-1:0] exp_ir = 5'h01;

    jtag_ir_dr_ctrl #(
        .IR_W       (IR_W),
        .IDCODE_VAL (IDV),
        .OP_IDCODE  (5'h01),
        .OP_USER0   (5'h10),
        .OP_USER1   (5'h11)
    ) dut (
        .tck          (tck),
        .trst         (trst),
        .tdi          (tdi),
        .tlr_n        (tlr_n),
        .select       (select),
        .capture_ir   (capture_ir),
        .shift_ir     (shift_ir),
        .update_ir    (update_ir),
        .capture_dr   (capture_dr),
        .shift_dr     (shift_dr),
        .update_dr    (update_dr),
        .tdo_en       (tdo_en),
        .tdo          (tdo),
        .tdo_oe       (tdo_oe),
        .ir_out       (ir_out),
        .user_sel     (user_sel),
        .user_capture (user_capture),
        .user_shift   (user_shift),
        .user_update  (user_update),
        .user_tdi     (user_tdi),
        .user_tdo     (user_tdo)
    );

    always #10 tck = ~tck;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One TAP state lasting one TCK period, entered just after rising TCK
    task automatic tap_state(input logic cir, input logic sir, input logic uir,
                             input logic cdr, input logic sdr, input logic udr,
                             input logic sel, input logic oe, input logic d);
        capture_ir = cir; shift_ir = sir; update_ir = uir;
        capture_dr = cdr; shift_dr = sdr; update_dr = udr;
        select = sel; tdo_en = oe; tdi = d;
        #2;
        check_eq("tdo_oe", 32'(tdo_oe), 32'(oe));
        check_eq("user_tdi", 32'(user_tdi), 32'(d));
        check_eq("user_strobes", 32'({user_capture, user_shift, user_update}),
                 32'({cdr, sdr, udr} & {3{exp_user_act}}));
        @(posedge tck);
        #1;
    endtask

    task automatic idle();
        tap_state(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ir_scan(input logic [IR_W-1:0] val, input logic both);
        logic [IR_W-1:0] m;
        m = 5'b00001;
        tap_state(1, both, 0, 0, 0, 0, 1, 0, 0);
        for (int unsigned i = 0; i < IR_W; i++) begin
            tdo_exp_q.push_back(m[0]);
            m = {val[i], m[IR_W-1:1]};
            tap_state(0, 1, 0, 0, 0, 0, 1, 1, val[i]);
        end
        tap_state(0, 0, 0, 0, 0, 0, 1, 0, 0);
        check_eq("ir_hold_before_update", 32'(ir_out), 32'(exp_ir));
        tap_state(0, 0, 1, 0, 0, 0, 1, 0, 0);
        check_eq("ir_after_update", 32'(ir_out), 32'(val));
        exp_ir = val;
        idle();
    endtask

    task automatic dr_scan(input logic [31:0] cap, input int unsigned reg_len,
                           input int unsigned n_shift, input logic [31:0] din,
                           input logic use_ext, input logic ext_bit);
        logic [31:0] m;
        m = cap;
        tap_state(0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int unsigned i = 0; i < n_shift; i++) begin
            tdo_exp_q.push_back(use_ext ? ext_bit : m[0]);
            m = m >> 1;
            m[reg_len-1] = din[i];
            tap_state(0, 0, 0, 0, 1, 0, 0, 1, din[i]);
        end
        tap_state(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tap_state(0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle();
    endtask

    // Scoreboard consumer: one expected TDO bit per enabled falling edge
    initial begin
        forever begin
            @(negedge tck);
            #1;
            if (tdo_oe === 1'b1) begin
                if (tdo_exp_q.size() == 0) begin
                    check_eq("tdo_unexpected_shift", 32'(tdo_exp_q.size()), 32'd1);
                end else begin
                    check_eq("tdo", 32'(tdo), 32'(tdo_exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        #2 trst = 1'b0;
        #3;
        check_eq("rst_ir_out", 32'(ir_out), 32'h01);
        check_eq("rst_tdo", 32'(tdo), 32'd0);
        check_eq("rst_user_sel", 32'(user_sel), 32'd0);
        check_eq("rst_strobes", 32'({user_capture, user_shift, user_update}), 32'd0);
        @(posedge tck);
        #1 trst = 1'b1;
        idle();

        // IDCODE scan straight out of reset, tdi held low
        dr_scan(IDV, 32, 32, 32'h0, 1'b0, 1'b0);
        check_eq("idcode_ir_out", 32'(ir_out), 32'h01);

        // BYPASS via all-ones, then a 4-bit DR scan with tdi = 1,0,1,1
        ir_scan(5'h1F, 1'b0);
        check_eq("bypass_user_sel", 32'(user_sel), 32'd0);
        dr_scan(32'h0, 1, 4, 32'b1101, 1'b0, 1'b0);

        // USER0 routes to external DR 0
        ir_scan(5'h10, 1'b0);
        check_eq("user0_sel", 32'(user_sel), 32'b01);
        exp_user_act = 1'b1;
        user_tdo = 2'b01;
        dr_scan(32'h0, 1, 3, 32'b010, 1'b1, 1'b1);
        exp_user_act = 1'b0;

        // Undecoded opcode with capture+shift overlap on the capture cycle
        ir_scan(5'h07, 1'b1);
        check_eq("undecoded_user_sel", 32'(user_sel), 32'd0);
        dr_scan(32'h0, 1, 3, 32'b011, 1'b0, 1'b0);

        // USER1 with Test-Logic-Reset forced mid Shift-DR
        ir_scan(5'h11, 1'b0);
        check_eq("user1_sel", 32'(user_sel), 32'b10);
        exp_user_act = 1'b1;
        user_tdo = 2'b10;
        tap_state(0, 0, 0, 1, 0, 0, 0, 0, 0);
        tdo_exp_q.push_back(1'b1);
        tap_state(0, 0, 0, 0, 1, 0, 0, 1, 0);
        tdo_exp_q.push_back(1'b1);
        tlr_n = 1'b0;
        tap_state(0, 0, 0, 0, 1, 0, 0, 1, 1);
        exp_user_act = 1'b0;
        check_eq("tlr_ir_out", 32'(ir_out), 32'h01);
        check_eq("tlr_user_sel", 32'(user_sel), 32'd0);
        tlr_n = 1'b1;
        idle();
        idle();

        check_eq("scoreboard_drained", 32'(tdo_exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
